// File: rtl/rst_pulse_stretcher.sv
// rst_pulse_stretcher: turns one-cycle reset request strobes into fixed-width active-low resets with hold-off
//   clk_i          in   system clock
//   rst_ni         in   asynchronous active-low reset (also forces every channel into its reset pulse)
//   rst_req_i      in   per-channel active-high reset request, sampled every posedge
//   periph_rst_no  out  per-channel active-low stretched reset, direct flop output
//   busy_o         out  per-channel asserting, holding off or request pending
//   done_o         out  per-channel 1-cycle pulse in the first cycle periph_rst_no is high again
module rst_pulse_stretcher #(
    parameter int N_CH           = 14,
    parameter int PULSE_CYCLES   = 16,
    parameter int HOLDOFF_CYCLES = 4
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic [N_CH-1:0] rst_req_i,
    output logic [N_CH-1:0] periph_rst_no,
    output logic [N_CH-1:0] busy_o,
    output logic [N_CH-1:0] done_o
);
    localparam int MAX_C = (PULSE_CYCLES > HOLDOFF_CYCLES) ? PULSE_CYCLES : HOLDOFF_CYCLES;
    localparam int CNT_W = $clog2(MAX_C + 1);
    localparam logic [CNT_W-1:0] PULSE_LD = CNT_W'(PULSE_CYCLES - 1);
    // Unused when there is no hold-off; clamped so the constant stays non-negative.
    localparam logic [CNT_W-1:0] HOLD_LD = CNT_W'((HOLDOFF_CYCLES > 0) ? HOLDOFF_CYCLES - 1 : 0);

    typedef enum logic [1:0] {IDLE, ASSERT, HOLDOFF} state_e;

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        state_e           state_q, state_d;
        logic [CNT_W-1:0] cnt_q, cnt_d;
        logic             pend_q, pend_d, done_d;
        logic             rst_n_q, busy_q, done_q;

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                state_q <= ASSERT;
                cnt_q   <= PULSE_LD;
                pend_q  <= 1'b0;
                rst_n_q <= 1'b0;
                busy_q  <= 1'b1;
                done_q  <= 1'b0;
            end else begin
                state_q <= state_d;
                cnt_q   <= cnt_d;
                pend_q  <= pend_d;
                // Outputs are registered from next-state so they are glitch-free and aligned with state.
                rst_n_q <= state_d != ASSERT;
                busy_q  <= (state_d != IDLE) | pend_d;
                done_q  <= done_d;
            end
        end

        always_comb begin
            state_d = state_q;
            cnt_d   = cnt_q;
            pend_d  = pend_q;
            done_d  = 1'b0;
            case (state_q)
                IDLE: begin
                    if (rst_req_i[i]) begin
                        state_d = ASSERT;
                        cnt_d   = PULSE_LD;
                    end
                end
                ASSERT: begin
                    // A request while asserting restarts the full width; it is not queued.
                    if (rst_req_i[i]) begin
                        cnt_d = PULSE_LD;
                    end else if (cnt_q != '0) begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end else begin
                        done_d  = 1'b1;
                        state_d = (HOLDOFF_CYCLES == 0) ? IDLE : HOLDOFF;
                        cnt_d   = HOLD_LD;
                    end
                end
                HOLDOFF: begin
                    if (cnt_q != '0) begin
                        cnt_d  = cnt_q - CNT_W'(1);
                        pend_d = pend_q | rst_req_i[i];
                    end else if (pend_q | rst_req_i[i]) begin
                        state_d = ASSERT;
                        cnt_d   = PULSE_LD;
                        pend_d  = 1'b0;
                    end else begin
                        state_d = IDLE;
                    end
                end
                default: begin
                    state_d = IDLE;
                    pend_d  = 1'b0;
                end
            endcase
        end

        assign periph_rst_no[i] = rst_n_q;
        assign busy_o[i]        = busy_q;
        assign done_o[i]        = done_q;
    end
endmodule

// File: tb/tb_rst_pulse_stretcher.sv
// tb_rst_pulse_stretcher: scoreboard bench for rst_pulse_stretcher (default build plus a no-hold-off build)
module tb_rst_pulse_stretcher;
    localparam int N = 14;

    typedef struct packed {
        logic [N-1:0] rst_n;
        logic [N-1:0] busy;
        logic [N-1:0] done;
    } exp_t;

    logic         clk_i = 1'b0;
    logic         rst_ni = 1'b1;
    logic [N-1:0] req = '0, req0 = '0;
    logic [N-1:0] prst_n, busy, done;
    logic [N-1:0] prst_n0, busy0, done0;
    exp_t         sb[$];
    int           checks = 0, errors = 0;

    always #5 clk_i = ~clk_i;

    rst_pulse_stretcher dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .rst_req_i(req),
        .periph_rst_no(prst_n), .busy_o(busy), .done_o(done)
    );

    rst_pulse_stretcher #(.HOLDOFF_CYCLES(0)) dut0 (
        .clk_i(clk_i), .rst_ni(rst_ni), .rst_req_i(req0),
        .periph_rst_no(prst_n0), .busy_o(busy0), .done_o(done0)
    );

    task automatic test_reset();
        exp_t e;
        #2 rst_ni = 1'b0;
        #1;
        checks += 4;
        if (prst_n !== '0) begin errors++; $display("FAIL reset_async rst_n got %h exp %h", prst_n, {N{1'b0}}); end
        if (busy !== '1) begin errors++; $display("FAIL reset_async busy got %h exp %h", busy, {N{1'b1}}); end
        if (done !== '0) begin errors++; $display("FAIL reset_async done got %h exp %h", done, {N{1'b0}}); end
        if (prst_n0 !== '0) begin errors++; $display("FAIL reset_async rst_n0 got %h exp %h", prst_n0, {N{1'b0}}); end
        repeat (3) @(negedge clk_i);
        rst_ni = 1'b1;
        for (int k = 1; k <= 24; k++) begin
            e.rst_n = (k >= 16) ? '1 : '0;
            e.busy  = (k < 20) ? '1 : '0;
            e.done  = (k == 16) ? '1 : '0;
            sb.push_back(e);
            @(posedge clk_i);
            @(negedge clk_i);
            e = sb.pop_front();
            checks += 3;
            if (prst_n !== e.rst_n) begin errors++; $display("FAIL reset_release rst_n k=%0d got %h exp %h", k, prst_n, e.rst_n); end
            if (busy !== e.busy) begin errors++; $display("FAIL reset_release busy k=%0d got %h exp %h", k, busy, e.busy); end
            if (done !== e.done) begin errors++; $display("FAIL reset_release done k=%0d got %h exp %h", k, done, e.done); end
        end
    endtask

    task automatic test_single();
        exp_t e;
        for (int k = 0; k < 24; k++) begin
            req = '0;
            req[3] = (k == 0);
            e.rst_n = '1; e.busy = '0; e.done = '0;
            e.rst_n[3] = (k >= 16);
            e.busy[3]  = (k < 20);
            e.done[3]  = (k == 16);
            sb.push_back(e);
            @(posedge clk_i);
            @(negedge clk_i);
            e = sb.pop_front();
            checks += 3;
            if (prst_n !== e.rst_n) begin errors++; $display("FAIL single rst_n k=%0d got %h exp %h", k, prst_n, e.rst_n); end
            if (busy !== e.busy) begin errors++; $display("FAIL single busy k=%0d got %h exp %h", k, busy, e.busy); end
            if (done !== e.done) begin errors++; $display("FAIL single done k=%0d got %h exp %h", k, done, e.done); end
        end
        req = '0;
    endtask

    task automatic test_extend();
        exp_t e;
        for (int k = 0; k < 34; k++) begin
            req = '0;
            req[3] = (k == 0 || k == 10);
            e.rst_n = '1; e.busy = '0; e.done = '0;
            e.rst_n[3] = (k >= 26);
            e.busy[3]  = (k < 30);
            e.done[3]  = (k == 26);
            sb.push_back(e);
            @(posedge clk_i);
            @(negedge clk_i);
            e = sb.pop_front();
            checks += 3;
            if (prst_n !== e.rst_n) begin errors++; $display("FAIL extend rst_n k=%0d got %h exp %h", k, prst_n, e.rst_n); end
            if (busy !== e.busy) begin errors++; $display("FAIL extend busy k=%0d got %h exp %h", k, busy, e.busy); end
            if (done !== e.done) begin errors++; $display("FAIL extend done k=%0d got %h exp %h", k, done, e.done); end
        end
        req = '0;
    endtask

    task automatic test_holdoff_rereq();
        exp_t e;
        for (int k = 0; k < 44; k++) begin
            req = '0;
            req[5] = (k == 0 || k == 18);
            e.rst_n = '1; e.busy = '0; e.done = '0;
            e.rst_n[5] = (k >= 16 && k < 20) || k >= 36;
            e.busy[5]  = (k < 40);
            e.done[5]  = (k == 16 || k == 36);
            sb.push_back(e);
            @(posedge clk_i);
            @(negedge clk_i);
            e = sb.pop_front();
            checks += 3;
            if (prst_n !== e.rst_n) begin errors++; $display("FAIL holdoff_rereq rst_n k=%0d got %h exp %h", k, prst_n, e.rst_n); end
            if (busy !== e.busy) begin errors++; $display("FAIL holdoff_rereq busy k=%0d got %h exp %h", k, busy, e.busy); end
            if (done !== e.done) begin errors++; $display("FAIL holdoff_rereq done k=%0d got %h exp %h", k, done, e.done); end
        end
        req = '0;
    endtask

    task automatic test_reset_mid();
        exp_t         e;
        logic [N-1:0] m;
        m = '0;
        m[1] = 1'b1; m[8] = 1'b1; m[13] = 1'b1;
        for (int k = 0; k <= 5; k++) begin
            req = (k == 0) ? m : '0;
            e.rst_n = ~m; e.busy = m; e.done = '0;
            sb.push_back(e);
            @(posedge clk_i);
            @(negedge clk_i);
            e = sb.pop_front();
            checks += 3;
            if (prst_n !== e.rst_n) begin errors++; $display("FAIL multi rst_n k=%0d got %h exp %h", k, prst_n, e.rst_n); end
            if (busy !== e.busy) begin errors++; $display("FAIL multi busy k=%0d got %h exp %h", k, busy, e.busy); end
            if (done !== e.done) begin errors++; $display("FAIL multi done k=%0d got %h exp %h", k, done, e.done); end
        end
        req = '0;
        #1 rst_ni = 1'b0;
        #1;
        checks += 3;
        if (prst_n !== '0) begin errors++; $display("FAIL mid_reset rst_n got %h exp %h", prst_n, {N{1'b0}}); end
        if (busy !== '1) begin errors++; $display("FAIL mid_reset busy got %h exp %h", busy, {N{1'b1}}); end
        if (done !== '0) begin errors++; $display("FAIL mid_reset done got %h exp %h", done, {N{1'b0}}); end
        repeat (2) @(negedge clk_i);
        rst_ni = 1'b1;
        for (int k = 1; k <= 24; k++) begin
            e.rst_n = (k >= 16) ? '1 : '0;
            e.busy  = (k < 20) ? '1 : '0;
            e.done  = (k == 16) ? '1 : '0;
            sb.push_back(e);
            @(posedge clk_i);
            @(negedge clk_i);
            e = sb.pop_front();
            checks += 3;
            if (prst_n !== e.rst_n) begin errors++; $display("FAIL mid_release rst_n k=%0d got %h exp %h", k, prst_n, e.rst_n); end
            if (busy !== e.busy) begin errors++; $display("FAIL mid_release busy k=%0d got %h exp %h", k, busy, e.busy); end
            if (done !== e.done) begin errors++; $display("FAIL mid_release done k=%0d got %h exp %h", k, done, e.done); end
        end
    endtask

    task automatic test_no_holdoff();
        exp_t e;
        for (int k = 0; k < 36; k++) begin
            req0 = '0;
            req0[2] = (k == 0 || k == 17);
            e.rst_n = '1; e.busy = '0; e.done = '0;
            e.rst_n[2] = (k == 16) || k >= 33;
            e.busy[2]  = (k < 16) || (k >= 17 && k < 33);
            e.done[2]  = (k == 16 || k == 33);
            sb.push_back(e);
            @(posedge clk_i);
            @(negedge clk_i);
            e = sb.pop_front();
            checks += 3;
            if (prst_n0 !== e.rst_n) begin errors++; $display("FAIL no_holdoff rst_n k=%0d got %h exp %h", k, prst_n0, e.rst_n); end
            if (busy0 !== e.busy) begin errors++; $display("FAIL no_holdoff busy k=%0d got %h exp %h", k, busy0, e.busy); end
            if (done0 !== e.done) begin errors++; $display("FAIL no_holdoff done k=%0d got %h exp %h", k, done0, e.done); end
        end
        req0 = '0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_extend();
        test_holdoff_rereq();
        test_reset_mid();
        test_no_holdoff();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
